// File: rtl/mips_cpu_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_bridge_pkg
// Shared definitions for the MIPS core <-> Avalon-MM memory bridge:
//   - bridge_state_t : bridge FSM states
//   - OP_*           : MIPS load/store primary opcodes (instr[31:26])
//   - BYTEEN_FULL    : all four byte lanes enabled
// ---------------------------------------------------------------------------
package mips_cpu_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DATA,
    COMMIT,
    HALT
  } bridge_state_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] BYTEEN_FULL = 4'hF;

endpackage

// File: rtl/mips_cpu_bridge_byteen.sv
// ---------------------------------------------------------------------------
// mips_cpu_bridge_byteen
// Combinational byte-lane decoder for sub-word stores.
//   i_opcode      : primary opcode of the latched instruction
//   i_addrLsb     : data address bits [1:0]
//   i_writedata   : store data from the core (value in the low bits)
//   o_byteenable  : Avalon byte lanes for the access
//   o_writedata   : store data replicated onto every lane
// SB/SH replicate the low byte/half so the slave sees the value on whichever
// lane the byteenable selects; every other access is a full word.
// ---------------------------------------------------------------------------
module mips_cpu_bridge_byteen
  import mips_cpu_bridge_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_addrLsb,
  input  logic [31:0] i_writedata,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata
);

  always_comb begin
    o_byteenable = BYTEEN_FULL;
    o_writedata  = i_writedata;
    case (i_opcode)
      OP_SB: begin
        o_byteenable = 4'b0001 << i_addrLsb;
        o_writedata  = {4{i_writedata[7:0]}};
      end
      OP_SH: begin
        o_byteenable = 4'b0011 << {i_addrLsb[1], 1'b0};
        o_writedata  = {2{i_writedata[15:0]}};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_bridge.sv
// ---------------------------------------------------------------------------
// mips_cpu_mem_bridge
// Serialises a Harvard MIPS core onto one Avalon-MM bus with waitrequest:
// each instruction is an instruction fetch, a decision cycle, an optional data
// access and a one-cycle commit strobe (core_clk_enable).
//
// Ports
//   clk, reset (async, active-low)
//   core_*  : core instruction/data ports, latched readdata, commit strobe
//   avm_*   : Avalon-MM master (address, read, write, writedata, byteenable,
//             readdata, waitrequest)
//   bus_error : sticky flag, set when a request stalls WAIT_TIMEOUT cycles
// Parameters
//   WAIT_TIMEOUT : stall cycles before bus_error (0 = never time out)
// Build option
//   MIPS_BRIDGE_BYTEEN_EN : when defined, SB/SH get narrow byteenables and
//   lane-replicated writedata; otherwise every access is a full word.
// ---------------------------------------------------------------------------
module mips_cpu_mem_bridge
  import mips_cpu_bridge_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_active,
  input  logic [31:0] core_instr_address,
  output logic [31:0] core_instr_readdata,
  input  logic [31:0] core_data_address,
  input  logic        core_data_read,
  input  logic        core_data_write,
  input  logic [31:0] core_data_writedata,
  output logic [31:0] core_data_readdata,
  output logic        core_clk_enable,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        bus_error
);

  bridge_state_t r_state;
  logic          r_fetchDone;
  logic          r_avmRead;
  logic          r_avmWrite;
  logic [31:0]   r_instr;
  logic [31:0]   r_loadData;
  logic          r_clkEn;
  logic          r_busError;
  logic [31:0]   r_waitCnt;

  logic          w_strobe;
  logic          w_inData;
  logic          w_timeout;
  logic [3:0]    w_dataBe;
  logic [31:0]   w_dataWd;
  logic          w_unusedAddrLsb;

`ifdef MIPS_BRIDGE_BYTEEN_EN
  mips_cpu_bridge_byteen u_byteen (
    .i_opcode     (r_instr[31:26]),
    .i_addrLsb    (core_data_address[1:0]),
    .i_writedata  (core_data_writedata),
    .o_byteenable (w_dataBe),
    .o_writedata  (w_dataWd)
  );
`else
  assign w_dataBe = BYTEEN_FULL;
  assign w_dataWd = core_data_writedata;
`endif

  // Word alignment is done on the bus side; the low address bits only matter
  // to the byte-lane decoder.
  assign w_unusedAddrLsb = ^{core_instr_address[1:0], core_data_address[1:0]};

  assign w_strobe  = r_avmRead | r_avmWrite;
  assign w_inData  = (r_state == DATA);
  assign w_timeout = (WAIT_TIMEOUT != 0) && (r_waitCnt == WAIT_TIMEOUT - 1);

  // The core holds its PC and data-port signals stable until it is clocked,
  // so the request fields can follow them directly while a strobe is held.
  // The fetch address must come live from the core because the PC only
  // advances on the same edge that starts the next FETCH.
  assign avm_address    = !w_strobe ? 32'h0 :
                          w_inData  ? {core_data_address[31:2], 2'b00} :
                                      {core_instr_address[31:2], 2'b00};
  assign avm_byteenable = !w_strobe ? 4'h0 : (w_inData ? w_dataBe : BYTEEN_FULL);
  assign avm_writedata  = r_avmWrite ? w_dataWd : 32'h0;
  assign avm_read       = r_avmRead;
  assign avm_write      = r_avmWrite;

  assign core_instr_readdata = r_instr;
  assign core_data_readdata  = r_loadData;
  assign core_clk_enable     = r_clkEn;
  assign bus_error           = r_busError;

  // Bridge FSM. Strobes and the commit pulse are registered and set on the
  // transition into the state that owns them. FETCH has two sub-phases: the
  // bus read, then (r_fetchDone) one decision cycle so the core's data-port
  // request is evaluated on the newly latched instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_fetchDone <= 1'b0;
      r_avmRead   <= 1'b0;
      r_avmWrite  <= 1'b0;
      r_instr     <= 32'h0;
      r_loadData  <= 32'h0;
      r_clkEn     <= 1'b0;
      r_busError  <= 1'b0;
      r_waitCnt   <= 32'h0;
    end else begin
      r_clkEn <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state   <= FETCH;
          r_avmRead <= 1'b1;
        end
        FETCH: begin
          if (!r_fetchDone) begin
            if (avm_waitrequest) begin
              if (w_timeout) begin
                r_busError <= 1'b1;
                r_avmRead  <= 1'b0;
                r_waitCnt  <= r_waitCnt + 32'd1;
                r_state    <= HALT;
              end else if (WAIT_TIMEOUT != 0) begin
                r_waitCnt <= r_waitCnt + 32'd1;
              end
            end else begin
              r_instr     <= avm_readdata;
              r_avmRead   <= 1'b0;
              r_fetchDone <= 1'b1;
              r_waitCnt   <= 32'h0;
            end
          end else begin
            r_fetchDone <= 1'b0;
            if (core_data_read | core_data_write) begin
              r_state    <= DATA;
              r_avmWrite <= core_data_write;
              r_avmRead  <= ~core_data_write;
            end else begin
              r_state <= COMMIT;
              r_clkEn <= 1'b1;
            end
          end
        end
        DATA: begin
          if (avm_waitrequest) begin
            if (w_timeout) begin
              r_busError <= 1'b1;
              r_avmRead  <= 1'b0;
              r_avmWrite <= 1'b0;
              r_waitCnt  <= r_waitCnt + 32'd1;
              r_state    <= HALT;
            end else if (WAIT_TIMEOUT != 0) begin
              r_waitCnt <= r_waitCnt + 32'd1;
            end
          end else begin
            if (r_avmRead) begin
              r_loadData <= avm_readdata;
            end
            r_avmRead  <= 1'b0;
            r_avmWrite <= 1'b0;
            r_waitCnt  <= 32'h0;
            r_state    <= COMMIT;
            r_clkEn    <= 1'b1;
          end
        end
        COMMIT: begin
          if (core_active) begin
            r_state   <= FETCH;
            r_avmRead <= 1'b1;
          end else begin
            r_state <= HALT;
          end
        end
        HALT: begin
        end
        default: begin
          r_state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_mem_bridge
// Bench for mips_cpu_mem_bridge with a small core model (PC advances on each
// commit, data-port requests decoded from the latched instruction) and an
// Avalon slave model with programmable waitstates. Accepted bus transfers are
// recorded and matched against an expected-transfer queue per scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_cpu_mem_bridge;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0020;
  localparam logic [31:0] LW_WORD   = 32'h8C00_0000;
  localparam logic [31:0] SW_WORD   = 32'hAC00_0000;
  localparam logic [31:0] SB_WORD   = 32'hA000_0000;
  localparam logic [31:0] BOOT_ADDR = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        isWrite;
    logic [31:0] wdata;
    logic [3:0]  be;
  } busTxn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_active = 1'b0;
  logic [31:0] core_instr_address;
  logic [31:0] core_instr_readdata;
  logic [31:0] core_data_address = 32'h0;
  logic        core_data_read;
  logic        core_data_write;
  logic [31:0] core_data_writedata = 32'h0;
  logic [31:0] core_data_readdata;
  logic        core_clk_enable;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        bus_error;

  logic [31:0] tbPcBase = 32'h0;
  logic [31:0] tbInstrWord = 32'h0;
  logic [31:0] tbLoadWord = 32'h0;
  int          tbFetchWaits = 0;
  int          tbDataWaits = 0;
  logic        tbStuck = 1'b0;
  logic        tbForceRW = 1'b0;

  int compared = 0;
  int mismatched = 0;
  int commitCount = 0;
  busTxn_t expBus[$];
  busTxn_t obsBus[$];

  always #5 clk = ~clk;

  mips_cpu_mem_bridge #(.WAIT_TIMEOUT(TB_TIMEOUT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .core_active         (core_active),
    .core_instr_address  (core_instr_address),
    .core_instr_readdata (core_instr_readdata),
    .core_data_address   (core_data_address),
    .core_data_read      (core_data_read),
    .core_data_write     (core_data_write),
    .core_data_writedata (core_data_writedata),
    .core_data_readdata  (core_data_readdata),
    .core_clk_enable     (core_clk_enable),
    .avm_address         (avm_address),
    .avm_read            (avm_read),
    .avm_write           (avm_write),
    .avm_writedata       (avm_writedata),
    .avm_byteenable      (avm_byteenable),
    .avm_readdata        (avm_readdata),
    .avm_waitrequest     (avm_waitrequest),
    .bus_error           (bus_error)
  );

  // Core model: PC steps by 4 on each commit; loads/stores are decoded from
  // the instruction the bridge is presenting.
  logic [31:0] pcOff;
  logic [5:0]  coreOp;
  always @(posedge clk or negedge reset) begin
    if (!reset) pcOff <= 32'h0;
    else if (core_clk_enable) pcOff <= pcOff + 32'd4;
  end
  assign core_instr_address = tbPcBase + pcOff;
  assign coreOp = core_instr_readdata[31:26];
  assign core_data_read  = tbForceRW || (coreOp == 6'h23) || (coreOp == 6'h20);
  assign core_data_write = tbForceRW || (coreOp == 6'h2B) || (coreOp == 6'h28);

  // Slave model: fetches live in the 0xB... region, everything else is data.
  int   slvCnt;
  logic slvBusy;
  logic slvIsFetch;
  assign slvBusy    = avm_read || avm_write;
  assign slvIsFetch = (avm_address[31:28] == 4'hB);
  assign avm_waitrequest = tbStuck ||
                           (slvBusy && (slvCnt < (slvIsFetch ? tbFetchWaits : tbDataWaits)));
  assign avm_readdata = slvIsFetch ? tbInstrWord : tbLoadWord;
  always @(posedge clk or negedge reset) begin
    if (!reset) slvCnt <= 0;
    else if (slvBusy && avm_waitrequest) slvCnt <= slvCnt + 1;
    else slvCnt <= 0;
  end

  // Record every accepted transfer and every commit strobe.
  always @(negedge clk) begin
    if (slvBusy && !avm_waitrequest)
      obsBus.push_back('{avm_address, avm_write, (avm_write ? avm_writedata : 32'h0), avm_byteenable});
    if (core_clk_enable) commitCount++;
  end

  task applyReset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    expBus.delete();
    obsBus.delete();
    reset = 1'b1;
  endtask

  task test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({avm_read, avm_write, avm_address, avm_byteenable} !== 38'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_bus: got rd=%b wr=%b addr=%h be=%h want all zero",
               avm_read, avm_write, avm_address, avm_byteenable);
    end
    compared++;
    if ({core_clk_enable, bus_error} !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got clken=%b err=%b want 0 0", core_clk_enable, bus_error);
    end
    compared++;
    if ({core_instr_readdata, core_data_readdata} !== 64'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_readdata: got instr=%h data=%h want 0 0",
               core_instr_readdata, core_data_readdata);
    end
  endtask

  task test_nonmem();
    int c0;
    tbPcBase = BOOT_ADDR; tbInstrWord = NOP_WORD; tbFetchWaits = 0; tbDataWaits = 0;
    tbStuck = 1'b0; tbForceRW = 1'b0; core_active = 1'b0;
    applyReset();
    c0 = commitCount;
    expBus.push_back('{BOOT_ADDR, 1'b0, 32'h0, 4'hF});
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        compared++;
        if ({avm_read, avm_address} !== {1'b1, BOOT_ADDR}) begin
          mismatched++;
          $display("[TB] FAIL nonmem_fetch: got rd=%b addr=%h want 1 %h", avm_read, avm_address, BOOT_ADDR);
        end
      end
      compared++;
      if (core_clk_enable !== (cyc == 3)) begin
        mismatched++;
        $display("[TB] FAIL nonmem_clken_c%0d: got %b want %b", cyc, core_clk_enable, (cyc == 3));
      end
    end
    compared++;
    if (core_instr_readdata !== NOP_WORD || (commitCount - c0) != 1) begin
      mismatched++;
      $display("[TB] FAIL nonmem_result: got instr=%h commits=%0d want %h 1",
               core_instr_readdata, commitCount - c0, NOP_WORD);
    end
    while (expBus.size() != 0) begin
      busTxn_t e;
      busTxn_t o;
      e = expBus.pop_front();
      compared++;
      if (obsBus.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL nonmem_bus: got nothing want %h", e);
      end else begin
        o = obsBus.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("[TB] FAIL nonmem_bus: got %h want %h", o, e);
        end
      end
    end
    compared++;
    if (obsBus.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL nonmem_extra: got %0d extra transfers want 0", obsBus.size());
    end
  endtask

  task test_load_waits();
    tbPcBase = BOOT_ADDR; tbInstrWord = LW_WORD; tbLoadWord = 32'hDEAD_BEEF;
    tbFetchWaits = 0; tbDataWaits = 2; tbStuck = 1'b0; tbForceRW = 1'b0; core_active = 1'b0;
    core_data_address = 32'h0000_1007;
    applyReset();
    expBus.push_back('{BOOT_ADDR, 1'b0, 32'h0, 4'hF});
    expBus.push_back('{32'h0000_1004, 1'b0, 32'h0, 4'hF});
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc <= 5) begin
        compared++;
        if ({avm_read, avm_write, avm_address} !== {2'b10, 32'h0000_1004}) begin
          mismatched++;
          $display("[TB] FAIL load_hold_c%0d: got rd=%b wr=%b addr=%h want 1 0 00001004",
                   cyc, avm_read, avm_write, avm_address);
        end
      end
      if (cyc == 5 || cyc == 6) begin
        compared++;
        if (core_data_readdata !== ((cyc == 6) ? 32'hDEAD_BEEF : 32'h0)) begin
          mismatched++;
          $display("[TB] FAIL load_data_c%0d: got %h want %h", cyc, core_data_readdata,
                   ((cyc == 6) ? 32'hDEAD_BEEF : 32'h0));
        end
      end
      compared++;
      if (core_clk_enable !== (cyc == 6)) begin
        mismatched++;
        $display("[TB] FAIL load_clken_c%0d: got %b want %b", cyc, core_clk_enable, (cyc == 6));
      end
    end
    while (expBus.size() != 0) begin
      busTxn_t e;
      busTxn_t o;
      e = expBus.pop_front();
      compared++;
      if (obsBus.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL load_bus: got nothing want %h", e);
      end else begin
        o = obsBus.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("[TB] FAIL load_bus: got %h want %h", o, e);
        end
      end
    end
  endtask

  task test_store_rw();
    tbPcBase = BOOT_ADDR; tbInstrWord = SW_WORD; tbFetchWaits = 0; tbDataWaits = 0;
    tbStuck = 1'b0; tbForceRW = 1'b1; core_active = 1'b0;
    core_data_address = 32'h0000_2000; core_data_writedata = 32'h1234_5678;
    applyReset();
    expBus.push_back('{BOOT_ADDR, 1'b0, 32'h0, 4'hF});
    expBus.push_back('{32'h0000_2000, 1'b1, 32'h1234_5678, 4'hF});
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        compared++;
        if ({avm_write, avm_read, avm_writedata, avm_byteenable} !== {2'b10, 32'h1234_5678, 4'hF}) begin
          mismatched++;
          $display("[TB] FAIL store_rw: got wr=%b rd=%b wd=%h be=%h want 1 0 12345678 f",
                   avm_write, avm_read, avm_writedata, avm_byteenable);
        end
      end
      compared++;
      if (core_clk_enable !== (cyc == 4)) begin
        mismatched++;
        $display("[TB] FAIL store_clken_c%0d: got %b want %b", cyc, core_clk_enable, (cyc == 4));
      end
    end
    tbForceRW = 1'b0;
    while (expBus.size() != 0) begin
      busTxn_t e;
      busTxn_t o;
      e = expBus.pop_front();
      compared++;
      if (obsBus.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL store_bus: got nothing want %h", e);
      end else begin
        o = obsBus.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("[TB] FAIL store_bus: got %h want %h", o, e);
        end
      end
    end
  endtask

  task test_timeout();
    int c0;
    logic [3:0] want;
    tbPcBase = BOOT_ADDR; tbInstrWord = NOP_WORD; tbFetchWaits = 0; tbDataWaits = 0;
    tbStuck = 1'b1; tbForceRW = 1'b0; core_active = 1'b1;
    applyReset();
    c0 = commitCount;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      want = (cyc <= 4) ? 4'b0100 : 4'b1000;
      compared++;
      if ({bus_error, avm_read, avm_write, core_clk_enable} !== want) begin
        mismatched++;
        $display("[TB] FAIL timeout_c%0d: got err/rd/wr/clken=%b want %b", cyc,
                 {bus_error, avm_read, avm_write, core_clk_enable}, want);
      end
      if (cyc == 6) tbStuck = 1'b0;
    end
    compared++;
    if ((commitCount - c0) != 0 || obsBus.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL timeout_quiet: got commits=%0d transfers=%0d want 0 0",
               commitCount - c0, obsBus.size());
    end
    core_active = 1'b0;
  endtask

  task test_reset_mid_data();
    int c0;
    tbPcBase = BOOT_ADDR; tbInstrWord = SW_WORD; tbFetchWaits = 0; tbDataWaits = 1;
    tbStuck = 1'b0; tbForceRW = 1'b0; core_active = 1'b0;
    core_data_address = 32'h0000_3000; core_data_writedata = 32'hCAFE_F00D;
    applyReset();
    c0 = commitCount;
    expBus.push_back('{BOOT_ADDR, 1'b0, 32'h0, 4'hF});
    expBus.push_back('{BOOT_ADDR, 1'b0, 32'h0, 4'hF});
    repeat (3) @(negedge clk);
    compared++;
    if ({avm_write, avm_address} !== {1'b1, 32'h0000_3000}) begin
      mismatched++;
      $display("[TB] FAIL midreset_pending: got wr=%b addr=%h want 1 00003000", avm_write, avm_address);
    end
    #1 reset = 1'b0;
    #1;
    compared++;
    if ({avm_read, avm_write, avm_address, avm_byteenable, core_clk_enable, bus_error} !== 40'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_bus: got rd=%b wr=%b addr=%h be=%h clken=%b err=%b want all zero",
               avm_read, avm_write, avm_address, avm_byteenable, core_clk_enable, bus_error);
    end
    compared++;
    if (core_instr_readdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL midreset_instr: got %h want 00000000", core_instr_readdata);
    end
    tbInstrWord = NOP_WORD;
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        compared++;
        if ({avm_read, avm_address} !== {1'b1, BOOT_ADDR}) begin
          mismatched++;
          $display("[TB] FAIL midreset_refetch: got rd=%b addr=%h want 1 %h", avm_read, avm_address, BOOT_ADDR);
        end
      end
    end
    compared++;
    if ((commitCount - c0) != 1) begin
      mismatched++;
      $display("[TB] FAIL midreset_commits: got %0d want 1", commitCount - c0);
    end
    while (expBus.size() != 0) begin
      busTxn_t e;
      busTxn_t o;
      e = expBus.pop_front();
      compared++;
      if (obsBus.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL midreset_bus_sb: got nothing want %h", e);
      end else begin
        o = obsBus.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("[TB] FAIL midreset_bus_sb: got %h want %h", o, e);
        end
      end
    end
    compared++;
    if (obsBus.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL midreset_extra: got %0d extra transfers want 0", obsBus.size());
    end
  endtask

  task test_back_to_back();
    tbPcBase = BOOT_ADDR; tbInstrWord = NOP_WORD; tbFetchWaits = 0; tbDataWaits = 0;
    tbStuck = 1'b0; tbForceRW = 1'b0; core_active = 1'b1;
    applyReset();
    expBus.push_back('{BOOT_ADDR, 1'b0, 32'h0, 4'hF});
    expBus.push_back('{BOOT_ADDR + 32'd4, 1'b0, 32'h0, 4'hF});
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        core_active = 1'b0;
        compared++;
        if ({avm_read, avm_address} !== {1'b1, BOOT_ADDR + 32'd4}) begin
          mismatched++;
          $display("[TB] FAIL b2b_fetch2: got rd=%b addr=%h want 1 %h", avm_read, avm_address, BOOT_ADDR + 32'd4);
        end
      end
      compared++;
      if (core_clk_enable !== (cyc == 3 || cyc == 6)) begin
        mismatched++;
        $display("[TB] FAIL b2b_clken_c%0d: got %b want %b", cyc, core_clk_enable, (cyc == 3 || cyc == 6));
      end
    end
    while (expBus.size() != 0) begin
      busTxn_t e;
      busTxn_t o;
      e = expBus.pop_front();
      compared++;
      if (obsBus.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL b2b_bus: got nothing want %h", e);
      end else begin
        o = obsBus.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("[TB] FAIL b2b_bus: got %h want %h", o, e);
        end
      end
    end
  endtask

`ifdef MIPS_BRIDGE_BYTEEN_EN
  task test_byteen_sb();
    tbPcBase = BOOT_ADDR; tbInstrWord = SB_WORD; tbFetchWaits = 0; tbDataWaits = 0;
    tbStuck = 1'b0; tbForceRW = 1'b0; core_active = 1'b0;
    core_data_address = 32'h0000_3002; core_data_writedata = 32'h0000_00AB;
    applyReset();
    expBus.push_back('{BOOT_ADDR, 1'b0, 32'h0, 4'hF});
    expBus.push_back('{32'h0000_3000, 1'b1, 32'hABAB_ABAB, 4'b0100});
    repeat (5) @(negedge clk);
    while (expBus.size() != 0) begin
      busTxn_t e;
      busTxn_t o;
      e = expBus.pop_front();
      compared++;
      if (obsBus.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL byteen_sb: got nothing want %h", e);
      end else begin
        o = obsBus.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("[TB] FAIL byteen_sb: got %h want %h", o, e);
        end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_load_waits();
    test_store_rw();
    test_timeout();
    test_reset_mid_data();
    test_back_to_back();
`ifdef MIPS_BRIDGE_BYTEEN_EN
    test_byteen_sb();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
